// File: rtl/fu_issue_arbiter_if.sv
// Issue-queue to FU handshake bundle: per-entry requests in, one-hot grant and
// the registered FU op out.
interface fu_issue_arbiter_if #(
    parameter int unsigned N_REQ = 8,
    parameter int unsigned N_SRC = 2,
    parameter int unsigned TAG_W = 6
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*N_SRC-1:0] req_src_rdy;
    logic [N_REQ*TAG_W-1:0] req_tag;
    logic [N_REQ-1:0]       grant;
    logic                   fu_valid;
    logic                   fu_ready;
    logic [TAG_W-1:0]       fu_tag;
    logic [IDX_W-1:0]       fu_idx;

    // master: issue queue and FU side; slave: the arbiter
    modport master (
        output req_valid, req_src_rdy, req_tag, fu_ready,
        input  grant, fu_valid, fu_tag, fu_idx
    );

    modport slave (
        input  req_valid, req_src_rdy, req_tag, fu_ready,
        output grant, fu_valid, fu_tag, fu_idx
    );
endinterface

// File: rtl/fu_issue_arbiter.sv
// Round-robin selection of one ready issue-queue entry per cycle into a one-deep
// output register feeding the FU over a valid/ready handshake.
module fu_issue_arbiter #(
    parameter int unsigned N_REQ = 8,
    parameter int unsigned N_SRC = 2,
    parameter int unsigned TAG_W = 6
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    fu_issue_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(N_REQ);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e           state_q;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] ptr_q;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] elig_hi;
    logic [IDX_W-1:0] win_hi;
    logic [IDX_W-1:0] win_all;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] ptr_next;
    logic             fu_valid;
    logic             load_en;

    always_comb begin
        eligible = '0;
        elig_hi  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            eligible[i] = bus.req_valid[i] & (&bus.req_src_rdy[i*N_SRC +: N_SRC]);
            elig_hi[i]  = eligible[i] & (IDX_W'(i) >= ptr_q);
        end
    end

    // Wrapping scan: lowest eligible index at or above ptr, else lowest overall.
    always_comb begin
        win_hi  = '0;
        win_all = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (elig_hi[i]) begin
                win_hi = IDX_W'(i);
            end
            if (eligible[i]) begin
                win_all = IDX_W'(i);
            end
        end
        winner = (|elig_hi) ? win_hi : win_all;
    end

    assign fu_valid = (state_q == StFull);
    assign load_en  = !rst && !flush && (!fu_valid || bus.fu_ready) && (|eligible);
    assign ptr_next = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        bus.grant = '0;
        if (load_en) begin
            bus.grant[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            tag_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else if (flush) begin
            state_q <= StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (load_en) begin
                        state_q <= StFull;
                    end
                end
                StFull: begin
                    if (bus.fu_ready && !load_en) begin
                        state_q <= StEmpty;
                    end
                end
                default: state_q <= StEmpty;
            endcase
            if (load_en) begin
                tag_q <= bus.req_tag[32'(winner)*TAG_W +: TAG_W];
                idx_q <= winner;
                ptr_q <= ptr_next;
            end
        end
    end

    assign bus.fu_valid = fu_valid;
    assign bus.fu_tag   = tag_q;
    assign bus.fu_idx   = idx_q;
endmodule
